// File: rtl/stereo_video_source_pkg.sv
// -----------------------------------------------------------------------------
// stereo_video_source_pkg
// Shared definitions for the stereo test-stream source:
//   - clog2       : ceiling log2 helper used to size counters and ports
//   - SYNC_*      : sync polarity (syncs are active high)
//   - pattern_e   : pattern_sel encodings
//   - state_e     : stream controller states
// -----------------------------------------------------------------------------
package stereo_video_source_pkg;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    localparam logic SYNC_ACTIVE = 1'b1;
    localparam logic SYNC_IDLE   = 1'b0;

    typedef enum logic [1:0] {
        PAT_RAMP    = 2'd0,  // x[7:0]
        PAT_BARS    = 2'd1,  // 4-pixel vertical bars
        PAT_CHECKER = 2'd2,  // 8x8 checkerboard
        PAT_HASH    = 2'd3   // (x*37 ^ y*11)[7:0]
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP_PEND
    } state_e;

endpackage

// File: rtl/stereo_video_source_pattern_gen.sv
// -----------------------------------------------------------------------------
// stereo_pattern_gen
// Combinational synthetic image generator P(x,y).
// Ports:
//   x           in  XW  horizontal position
//   y           in  YW  vertical position
//   pattern_sel in  2   pattern_e encoding
//   pixel       out 8   pattern value at (x,y)
// -----------------------------------------------------------------------------
module stereo_pattern_gen
    import stereo_video_source_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 8
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    pattern_sel,
    output logic [7:0]    pixel
);

    logic [15:0] xe;
    logic [15:0] ye;
    logic [7:0]  hash;

    always_comb begin
        xe    = 16'(x);
        ye    = 16'(y);
        // Products are formed at 16 bits and only the low byte is kept.
        hash  = 8'((xe * 16'd37) ^ (ye * 16'd11));
        pixel = '0;
        case (pattern_e'(pattern_sel))
            PAT_RAMP:    pixel = xe[7:0];
            PAT_BARS:    pixel = xe[2] ? '1 : '0;
            PAT_CHECKER: pixel = (xe[3] ^ ye[3]) ? '1 : '0;
            PAT_HASH:    pixel = hash;
            default:     pixel = '0;
        endcase
    end

endmodule

// File: rtl/stereo_video_source.sv
// -----------------------------------------------------------------------------
// stereo_video_source
// Stereo test-stream transmitter: raster timing plus a synthetic left image and
// a right image shifted by a programmable disparity d.
// Ports:
//   clk          in  1   pixel clock
//   rst_n        in  1   asynchronous active-low reset
//   enable       in  1   run request
//   disp_sel     in  DW  disparity d (clamped to DISPARITY_RANGE-1)
//   pattern_sel  in  2   pattern select (see pattern_e)
//   de_out       out 1   active video
//   h_sync_out   out 1   horizontal sync, active high
//   v_sync_out   out 1   vertical sync, active high
//   pixel_left   out 8   P(x,y)
//   pixel_right  out 8   P(x+d,y), 0 when x+d >= H_ACTIVE
//   frame_start  out 1   pulse with pixel (0,0)
//   busy         out 1   stream running or finishing its last frame
// -----------------------------------------------------------------------------
module stereo_video_source
    import stereo_video_source_pkg::*;
#(
    parameter int H_ACTIVE        = 64,
    parameter int H_FP            = 4,
    parameter int H_SYNC          = 8,
    parameter int H_BP            = 4,
    parameter int V_ACTIVE        = 64,
    parameter int V_FP            = 2,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 2,
    parameter int DISPARITY_RANGE = 8,
    localparam int DW = (clog2(DISPARITY_RANGE) > 0) ? clog2(DISPARITY_RANGE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [DW-1:0] disp_sel,
    input  logic [1:0]    pattern_sel,
    output logic          de_out,
    output logic          h_sync_out,
    output logic          v_sync_out,
    output logic [7:0]    pixel_left,
    output logic [7:0]    pixel_right,
    output logic          frame_start,
    output logic          busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = clog2(H_TOTAL);
    localparam int VW      = clog2(V_TOTAL);
    localparam int XRW     = HW + 1;

    localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  H_SS     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  V_SS     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [XRW-1:0] H_ACT_XR = XRW'(H_ACTIVE);
    localparam logic [DW-1:0]  D_MAX    = DW'(DISPARITY_RANGE - 1);

    state_e         state;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic [DW-1:0]  d_lat;
    logic [1:0]     pat_lat;

    logic           at_origin;
    logic           at_last;
    logic [DW-1:0]  d_in;
    logic [DW-1:0]  d_eff;
    logic [1:0]     pat_eff;
    logic           active;
    logic           h_sync;
    logic           v_sync;
    logic [XRW-1:0] x_right;
    logic           right_valid;
    logic [7:0]     pix_l;
    logic [7:0]     pix_r;

    always_comb begin
        at_origin   = (h_cnt == '0) && (v_cnt == '0);
        at_last     = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        d_in        = (disp_sel > D_MAX) ? D_MAX : disp_sel;
        // Pixel (0,0) is produced in the same cycle the settings are latched,
        // so it must see the incoming values rather than the stale latch.
        d_eff       = at_origin ? d_in : d_lat;
        pat_eff     = at_origin ? pattern_sel : pat_lat;
        active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        h_sync      = (h_cnt >= H_SS) && (h_cnt < H_SE);
        v_sync      = (v_cnt >= V_SS) && (v_cnt < V_SE);
        x_right     = XRW'(h_cnt) + XRW'(d_eff);
        right_valid = (x_right < H_ACT_XR);
    end

    stereo_pattern_gen #(
        .XW (HW),
        .YW (VW)
    ) u_pat_left (
        .x           (h_cnt),
        .y           (v_cnt),
        .pattern_sel (pat_eff),
        .pixel       (pix_l)
    );

    stereo_pattern_gen #(
        .XW (XRW),
        .YW (VW)
    ) u_pat_right (
        .x           (x_right),
        .y           (v_cnt),
        .pattern_sel (pat_eff),
        .pixel       (pix_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            d_lat       <= '0;
            pat_lat     <= '0;
            de_out      <= 1'b0;
            h_sync_out  <= SYNC_IDLE;
            v_sync_out  <= SYNC_IDLE;
            pixel_left  <= '0;
            pixel_right <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (at_origin) begin
                d_lat   <= d_in;
                pat_lat <= pattern_sel;
            end

            if (state == ST_IDLE) begin
                h_cnt       <= '0;
                v_cnt       <= '0;
                de_out      <= 1'b0;
                h_sync_out  <= SYNC_IDLE;
                v_sync_out  <= SYNC_IDLE;
                pixel_left  <= '0;
                pixel_right <= '0;
                frame_start <= 1'b0;
                if (enable) begin
                    state <= ST_RUN;
                    busy  <= 1'b1;
                end
            end else begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end

                de_out      <= active;
                h_sync_out  <= h_sync ? SYNC_ACTIVE : SYNC_IDLE;
                v_sync_out  <= v_sync ? SYNC_ACTIVE : SYNC_IDLE;
                pixel_left  <= active ? pix_l : '0;
                pixel_right <= (active && right_valid) ? pix_r : '0;
                frame_start <= at_origin;

                // Stopping only ever takes effect on the frame's last pixel,
                // so a started frame always runs through its blanking.
                if (enable) begin
                    state <= ST_RUN;
                end else if (at_last) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end else begin
                    state <= ST_STOP_PEND;
                end
            end
        end
    end

endmodule

// File: tb/tb_stereo_video_source.sv
module tb_stereo_video_source;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1;
    localparam int DR = 8;
    localparam int HT = HA + HFP + HS + HBP;   // 24
    localparam int VT = VA + VFP + VS + VBP;   // 8
    localparam int FRAME = HT * VT;            // 192

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [2:0] disp_sel;
    logic [1:0] pattern_sel;
    logic       de_out, h_sync_out, v_sync_out, frame_start, busy;
    logic [7:0] pixel_left, pixel_right;

    always #5 clk = ~clk;

    stereo_video_source #(
        .H_ACTIVE        (HA),
        .H_FP            (HFP),
        .H_SYNC          (HS),
        .H_BP            (HBP),
        .V_ACTIVE        (VA),
        .V_FP            (VFP),
        .V_SYNC          (VS),
        .V_BP            (VBP),
        .DISPARITY_RANGE (DR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .disp_sel    (disp_sel),
        .pattern_sel (pattern_sel),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .pixel_left  (pixel_left),
        .pixel_right (pixel_right),
        .frame_start (frame_start),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: whether the stream is live, which raster position
    // the next output shows, and the settings in force for the current frame.
    bit m_run  = 1'b0;
    int m_pos  = 0;
    int m_d    = 0;
    int m_pat  = 0;
    int last_p = -1;

    function automatic int pat_val(int pat, int x, int y);
        case (pat)
            0:       return x % 256;
            1:       return ((x / 4) % 2 == 1) ? 255 : 0;
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 255 : 0;
            default: return ((x * 37) ^ (y * 11)) % 256;
        endcase
    endfunction

    // Expected {de, hs, vs, fs, busy, left, right} for raster position p.
    function automatic logic [20:0] expect_at(int p, int d, int pat, bit bsy);
        int x;
        int y;
        bit de, hs, vs, fs;
        logic [7:0] l, r;
        x  = p % HT;
        y  = p / HT;
        de = (x < HA) && (y < VA);
        hs = (x >= HA + HFP) && (x < HA + HFP + HS);
        vs = (y >= VA + VFP) && (y < VA + VFP + VS);
        fs = (p == 0);
        l  = de ? 8'(pat_val(pat, x, y)) : 8'h00;
        r  = (de && (x + d < HA)) ? 8'(pat_val(pat, x + d, y)) : 8'h00;
        return {de, hs, vs, fs, bsy, l, r};
    endfunction

    task automatic check(string tag, int p, logic [20:0] exp_v);
        logic [20:0] obs;
        obs = {de_out, h_sync_out, v_sync_out, frame_start, busy, pixel_left, pixel_right};
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s p=%0d observed=%h expected=%h", tag, p, obs, exp_v);
        end
    endtask

    // One clock of normal operation (rst_n high) with model update.
    task automatic cycle(string tag);
        logic [20:0] exp_v;
        int shown;
        if (m_run && m_pos == 0) begin
            m_d   = (int'(disp_sel) > DR - 1) ? DR - 1 : int'(disp_sel);
            m_pat = int'(pattern_sel);
        end
        if (m_run) begin
            shown = m_pos;
            if (m_pos == FRAME - 1 && !enable) begin
                m_run = 1'b0;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            exp_v = expect_at(shown, m_d, m_pat, m_run);
        end else begin
            shown = -1;
            m_run = enable;
            m_pos = 0;
            exp_v = {4'b0, m_run, 16'h0000};
        end
        @(posedge clk);
        #1;
        last_p = shown;
        check(tag, shown, exp_v);
    endtask

    task automatic reset_cycle(string tag);
        m_run = 1'b0;
        m_pos = 0;
        @(posedge clk);
        #1;
        last_p = -1;
        check(tag, -1, 21'h0);
    endtask

    task automatic run_to(string tag, int target);
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            cycle(tag);
            if (last_p == target) return;
        end
        n_tests++;
        n_fail++;
        $error("FAIL %s_timeout observed=%0d expected=%0d", tag, last_p, target);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        disp_sel    = 3'd0;
        pattern_sel = 2'd0;

        repeat (3) reset_cycle("reset");
        rst_n = 1'b1;
        repeat (2) cycle("idle");

        // Timing frame with d=0; d changes to 5 mid-frame, applies next frame.
        enable = 1'b1;
        cycle("start");
        run_to("frame1", 50);
        disp_sel = 3'd5;
        run_to("frame1", FRAME - 1);
        run_to("frame2", 100);
        disp_sel = 3'd3;
        run_to("frame2", FRAME - 1);
        run_to("frame3_d3", 100);
        pattern_sel = 2'd3;
        disp_sel    = 3'd6;
        run_to("frame3_d3", FRAME - 1);
        run_to("frame4_hash_d6", FRAME - 1);

        for (int f = 0; f < 4; f++) begin
            run_to("random", int'($urandom_range(1, FRAME - 2)));
            disp_sel    = 3'($urandom_range(0, 7));
            pattern_sel = 2'($urandom_range(0, 3));
            run_to("random", FRAME - 1);
        end

        // Drop and restore enable mid-frame: stream must not break.
        run_to("resume", 100);
        enable = 1'b0;
        run_to("resume", 110);
        enable = 1'b1;
        run_to("resume", FRAME - 1);

        // Drop enable and keep it low: frame completes, then idle.
        run_to("stop", 100);
        enable = 1'b0;
        run_to("stop", FRAME - 1);
        repeat (3) cycle("stopped_idle");

        // Enable falling exactly on the wrap cycle.
        enable = 1'b1;
        cycle("restart");
        run_to("restart", FRAME - 2);
        enable = 1'b0;
        cycle("wrap_stop");
        repeat (2) cycle("wrap_idle");

        // Enable returning exactly on the wrap cycle while stop is pending.
        enable = 1'b1;
        cycle("restart2");
        run_to("pend", 150);
        enable = 1'b0;
        run_to("pend", FRAME - 2);
        enable = 1'b1;
        run_to("pend_cont", 5);

        // Asynchronous reset during h_sync of line 2.
        run_to("pre_reset", 2 * HT + HA + HFP);
        #2;
        rst_n = 1'b0;
        #1;
        m_run = 1'b0;
        m_pos = 0;
        check("reset_async", -1, 21'h0);
        repeat (2) reset_cycle("reset_hold");
        rst_n = 1'b1;
        cycle("post_reset");
        run_to("post_reset", FRAME - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stereo_video_source.md
Name: stereo_video_source

Overview:
- Stereo test-stream transmitter that feeds the disparity pipeline's video input (de/h_sync/v_sync plus left/right 8-bit pixels).
- Generates raster timing and a synthetic left image P(x,y); the right image is the same image shifted by a programmable disparity d, so the matcher must report d.
- Used as on-chip stimulus for bring-up and as the bench source for the matcher.

Parameters:
- H_ACTIVE, 64, active pixels per line
- H_FP, 4, horizontal front porch (cycles)
- H_SYNC, 8, h_sync width (cycles)
- H_BP, 4, horizontal back porch (cycles)
- V_ACTIVE, 64, active lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, v_sync width (lines)
- V_BP, 2, vertical back porch (lines)
- DISPARITY_RANGE, 8, number of disparities; DW = clog2(DISPARITY_RANGE)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request
- disp_sel  in  DW  disparity d applied to the right image
- pattern_sel  in  2  0 = x ramp, 1 = 4-px vertical bars, 2 = 8x8 checker, 3 = hash
- de_out  out  1  active-video flag
- h_sync_out  out  1  horizontal sync, active high
- v_sync_out  out  1  vertical sync, active high
- pixel_left  out  8  P(x,y)
- pixel_right  out  8  P(x+d,y), or 0 if x+d >= H_ACTIVE
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- busy  out  1  high in RUN or STOP_PEND

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the same sum over the V parameters.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0, incrementing v_cnt. v_cnt runs 0..V_TOTAL-1 and wraps to 0.
- Decode (position counts x = h_cnt, y = v_cnt):
  - active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
  - h_sync when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines
  - v_sync when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line
- Outputs: all registered, 1-cycle latency from the counters. pixel_left and pixel_right are 0 whenever de_out = 0.
- Patterns (x, y as counter values):
  - 0: x[7:0]
  - 1: 8'hFF if x[2] else 8'h00
  - 2: 8'hFF if x[3]^y[3] else 8'h00
  - 3: (x*37 ^ y*11)[7:0], products computed 16-bit and truncated
- Right pixel: evaluate the pattern at x+d, computed one bit wider than h_cnt; out-of-range (x+d >= H_ACTIVE) gives 0.
- Disparity clamp: d = min(disp_sel, DISPARITY_RANGE-1).
- Frame-boundary latching: d and pattern_sel are latched only at frame start (h_cnt = 0, v_cnt = 0). Mid-frame changes take effect at the next frame.
- FSM states: IDLE, RUN, STOP_PEND.
  - IDLE: counters held at 0; all outputs 0.
  - IDLE -> RUN when enable = 1. The counters start at (0,0) in the following cycle; the first de_out appears 2 cycles after enable is sampled high.
  - RUN -> STOP_PEND when enable = 0.
  - STOP_PEND -> RUN if enable returns to 1 before the frame ends (no glitch, frame continues).
  - STOP_PEND -> IDLE when the counters wrap to (0,0); the final frame always completes, including vertical blanking.
  - Simultaneous: enable falling on the exact wrap cycle goes to IDLE with no extra frame.
- frame_start: asserted with the registered outputs of (0,0) only.
- Reset: asynchronous rst_n low at any time, including mid-line or mid-sync, forces IDLE, counters 0, and every output 0 (de_out, h_sync_out, v_sync_out, pixels, frame_start, busy). The stream restarts from (0,0) after release if enable = 1.

Decomposition:
- Shared include: clog2 function (existing util), sync polarity constants, pattern_sel encodings.
- Timing totals: localparams in the top module.
- One combinational sub-module, stereo_pattern_gen, instantiated twice (left at x, right at x+d). Inputs: x, y, pattern_sel. Output: 8-bit value.

Test Plan:
All scenarios use H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24) and V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8).
- Timing: enable=1, pattern 0, d=0 -> 16 de cycles per line. h_sync high at line offsets 18..20. v_sync high on lines 5..6. Frame period 192 cycles. frame_start every 192 cycles.
- Disparity: pattern 0, d=3 -> line 0 left = 0..15; right = 3..15 then 0,0,0.
- Latching: d changed 0->5 at cycle 50 of frame 1 -> frame 1 right = left throughout; frame 2 right(x) = x+5.
- Stop: enable dropped at cycle 100 -> outputs continue to cycle 191, then IDLE with busy = 0 and all outputs 0. Re-enable at cycle 110 -> uninterrupted next frame.
- Reset: rst_n pulsed low during h_sync of line 2 -> all outputs 0 in the same cycle. After release with enable = 1, frame_start occurs 2 cycles later.
- Match check: pattern 3, d=6, stream into the disparity matcher -> every pixel with x <= 9 yields disparity 6.
